seq_signed_divider: RTL and testbench

- Multi-cycle signed divider; the inverse of the 32x32 signed multiplier path.
- Divides a signed 64-bit dividend, such as a multiplier product, by a signed 32-bit divisor.
- Returns a signed 32-bit quotient and a signed 32-bit remainder.
- Uses a radix-2 restoring algorithm on magnitudes: one quotient bit per cycle, fixed latency, start/done handshake, global en stall like the codebase buffers.

---
 rtl/seq_signed_divider.sv | 189 ++++++++++++++++++
 tb/tb_seq_signed_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_signed_divider
//  Description : Multi-cycle radix-2 restoring signed divider, 64b / 32b ->
//                32b quotient + 32b remainder, start/done handshake, en stall.
//                Optional macro DIV_SAT_EN: saturate quotient on overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_signed_divider #(
    parameter int DW = 64,                // dividend width, must be 2*QW
    parameter int QW = 32                 // divisor / quotient / remainder width
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [QW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient,
    output logic [QW-1:0] remainder,
    output logic          div_by_zero,
    output logic          overflow
);

    localparam int          CW     = $clog2(DW);
    localparam logic [CW-1:0] C_LAST = CW'(DW - 1);
    localparam logic [QW-1:0] C_QMAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] C_QMIN = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ADJ  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [QW:0]     rem_q, rem_d;        // 33-bit partial remainder
    logic [DW-1:0]   dvd_q, dvd_d;        // dividend shifter, becomes quotient
    logic [QW-1:0]   dsr_q, dsr_d;        // |divisor|
    logic [QW-1:0]   dvd_lo_q, dvd_lo_d;  // raw dividend low word for div-by-zero
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            zero_q, zero_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [QW-1:0]   quot_q, quot_d;
    logic [QW-1:0]   rmd_q, rmd_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [QW:0]     w_rem_shift;
    logic [QW+1:0]   w_trial;
    logic [DW-QW:0]  w_qhi;
    logic            w_ovf;

    always_comb begin
        w_rem_shift = {rem_q[QW-1:0], dvd_q[DW-1]};
        w_trial     = {1'b0, w_rem_shift} - {2'b00, dsr_q};
        // Full quotient fits in QW signed bits only if its top bits are all equal
        w_qhi       = dvd_q[DW-1:QW-1];
        w_ovf       = ~zero_q & ~((&w_qhi) | ~(|w_qhi));

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        dvd_lo_d = dvd_lo_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = done_q;
        quot_d   = quot_q;
        rmd_d    = rmd_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    dvd_d    = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
                    dsr_d    = divisor[QW-1] ? (~divisor + 1'b1) : divisor;
                    dvd_lo_d = dividend[QW-1:0];
                    neg_q_d  = dividend[DW-1] ^ divisor[QW-1];
                    neg_r_d  = dividend[DW-1];
                    zero_d   = (divisor == '0);
                    rem_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (w_trial[QW+1]) begin
                    rem_d = w_rem_shift;
                end else begin
                    rem_d = w_trial[QW:0];
                end
                dvd_d = {dvd_q[DW-2:0], ~w_trial[QW+1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == C_LAST) begin
                    state_d = S_ADJ;
                end
            end
            S_ADJ: begin
                // Apply signs in place so FIX only has to range-check and load
                dvd_d   = neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
                rem_d   = neg_r_q ? (~rem_q + 1'b1) : rem_q;
                state_d = S_FIX;
            end
            S_FIX: begin
                dbz_d = zero_q;
                ovf_d = w_ovf;
                if (zero_q) begin
                    quot_d = '0;
                    rmd_d  = dvd_lo_q;
                end else begin
`ifdef DIV_SAT_EN
                    if (w_ovf) begin
                        quot_d = neg_q_q ? C_QMIN : C_QMAX;
                    end else begin
                        quot_d = dvd_q[QW-1:0];
                    end
`else
                    quot_d = dvd_q[QW-1:0];
`endif
                    rmd_d  = rem_q[QW-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            dvd_lo_q <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            quot_q   <= '0;
            rmd_q    <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            dvd_lo_q <= dvd_lo_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            quot_q   <= quot_d;
            rmd_q    <= rmd_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_signed_divider
//  Description : Directed self-checking bench for seq_signed_divider.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_signed_divider;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    wire         busy;
    wire         done;
    wire  [31:0] quotient;
    wire  [31:0] remainder;
    wire         div_by_zero;
    wire         overflow;

    int n_tests = 0;
    int n_fail  = 0;

    seq_signed_divider #(.DW(64), .QW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns the number of edges until done is seen, 0 on timeout
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input logic eov);
        int lat;
        issue(a, b);
        check({tag, " busy"}, {63'b0, busy}, 64'd1);
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'd66);
        check({tag, " q"}, {32'b0, quotient}, {32'b0, eq});
        check({tag, " r"}, {32'b0, remainder}, {32'b0, er});
        check({tag, " dbz"}, {63'b0, div_by_zero}, {63'b0, edz});
        check({tag, " ovf"}, {63'b0, overflow}, {63'b0, eov});
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        int k;
        logic [31:0] sat_pos;
        logic [31:0] sat_neg;
`ifdef DIV_SAT_EN
        sat_pos = 32'h7FFF_FFFF;
        sat_neg = 32'h8000_0000;
`else
        sat_pos = 32'h0000_0000;
        sat_neg = 32'h0000_0000;
`endif
        rst = 1'b1; en = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset done", {63'b0, done}, 64'd0);
        check("reset q", {32'b0, quotient}, 64'd0);
        check("reset r", {32'b0, remainder}, 64'd0);
        check("reset flags", {62'b0, div_by_zero, overflow}, 64'd0);

        run_op("100/7",   64'sd100,  32'sd7,  32'sd14,  32'sd2,  1'b0, 1'b0);
        run_op("-100/7",  -64'sd100, 32'sd7,  -32'sd14, -32'sd2, 1'b0, 1'b0);
        run_op("100/-7",  64'sd100,  -32'sd7, -32'sd14, 32'sd2,  1'b0, 1'b0);
        run_op("-100/-7", -64'sd100, -32'sd7, 32'sd14,  -32'sd2, 1'b0, 1'b0);
        run_op("mulinv",  -64'sd740740734, -32'sd123456789, 32'sd6, 32'sd0, 1'b0, 1'b0);
        run_op("maxsq",   64'h3FFF_FFFF_0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0);
        run_op("5/0",     64'sd5, 32'd0, 32'd0, 32'd5, 1'b1, 1'b0);
        run_op("-5/0",    -64'sd5, 32'd0, 32'd0, 32'hFFFF_FFFB, 1'b1, 1'b0);
        run_op("2^32/1",  64'h0000_0001_0000_0000, 32'd1, sat_pos, 32'd0, 1'b0, 1'b1);
        run_op("min/-1",  64'h8000_0000_0000_0000, 32'hFFFF_FFFF, sat_pos, 32'd0, 1'b0, 1'b1);
        run_op("min/1",   64'h8000_0000_0000_0000, 32'd1, sat_neg, 32'd0, 1'b0, 1'b1);
        run_op("-7/2",    -64'sd7, 32'sd2, -32'sd3, -32'sd1, 1'b0, 1'b0);

        // start pulsed while busy must be ignored
        issue(64'sd100, 32'sd7);
        repeat (9) @(posedge clk);
        #1;
        dividend = 64'sd9; divisor = 32'sd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("busy-start latency", 64'(lat + 10), 64'd66);
        check("busy-start q", {32'b0, quotient}, 64'd14);
        count_dones("busy-start extra done", 80);

        // start held high: the done cycle accepts the next operation
        @(negedge clk);
        dividend = 64'sd9; divisor = 32'sd2; start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("hold latency1", 64'(lat), 64'd66);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold reaccept busy", {63'b0, busy}, 64'd1);
        check("hold reaccept done", {63'b0, done}, 64'd0);
        wait_done(lat);
        check("hold latency2", 64'(lat), 64'd66);
        check("hold q", {32'b0, quotient}, 64'd4);

        // 10-cycle stall mid-CALC, then stretched done
        issue(-64'sd100, 32'sd7);
        repeat (20) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        en = 1'b1;
        k = 30;
        wait_done(lat);
        check("stall latency", 64'(lat + k), 64'd76);
        check("stall q", {32'b0, quotient}, {32'b0, -32'sd14});
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall done held", {63'b0, done}, 64'd1);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("stall done drop", {63'b0, done}, 64'd0);

        // reset in the middle of CALC
        issue(64'sd100, 32'sd7);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst busy", {63'b0, busy}, 64'd0);
        check("midrst q", {32'b0, quotient}, 64'd0);
        check("midrst r", {32'b0, remainder}, 64'd0);
        check("midrst flags", {61'b0, done, div_by_zero, overflow}, 64'd0);
        count_dones("midrst no done", 80);
        run_op("9/2", 64'sd9, 32'sd2, 32'sd4, 32'sd1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
